// File: rtl/top2_frame_ctrl.sv
// top2_frame_ctrl: frame-level sequencer around a streaming top-2 tracker.
// A start latches the frame length and clears the tracker. ACCUM then takes
// samples until the length is reached or s_last is seen. RESULT holds the
// largest/second-largest pair on a valid/ready port until it is consumed.
// All outputs come straight from registers, so no input reaches an output
// combinationally.
module top2_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [LEN_W-1:0]      frame_len,
  output logic                  busy,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_largest,
  output logic [DATA_WIDTH-1:0] m_second,
  output logic [LEN_W-1:0]      m_count,
  output logic                  m_second_valid
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  state_t                  state_q;
  logic [LEN_W-1:0]        len_q;
  logic [DATA_WIDTH-1:0]   largest_q;
  logic [DATA_WIDTH-1:0]   second_q;
  logic [LEN_W-1:0]        count_q;
  logic                    second_valid_q;
  logic                    s_ready_q;
  logic                    m_valid_q;
  logic                    busy_q;

  logic                    beat_s;
  logic                    frame_end_s;
  logic [LEN_W-1:0]        count_d;
  logic [DATA_WIDTH-1:0]   largest_d;
  logic [DATA_WIDTH-1:0]   second_d;

  // Tracker next values for an accepted beat, plus the frame-end decision.
  always_comb begin
    beat_s    = s_ready_q && s_valid;
    count_d   = count_q + LEN_W'(1);
    largest_d = largest_q;
    second_d  = second_q;
    if (s_data > largest_q) begin
      // New maximum: the old maximum becomes the runner-up.
      largest_d = s_data;
      second_d  = largest_q;
    end else if (s_data > second_q) begin
      // Equal-to-largest lands here too, so duplicates count as second.
      largest_d = largest_q;
      second_d  = s_data;
    end else begin
      largest_d = largest_q;
      second_d  = second_q;
    end
    // count never passes len_q, so count_d cannot wrap before matching.
    frame_end_s = (count_d == len_q) || s_last;
  end

  // Frame FSM with registered handshake/status outputs and tracker state.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      largest_q      <= '0;
      second_q       <= '0;
      count_q        <= '0;
      second_valid_q <= 1'b0;
      s_ready_q      <= 1'b0;
      m_valid_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q          <= frame_len;
            largest_q      <= '0;
            second_q       <= '0;
            count_q        <= '0;
            second_valid_q <= 1'b0;
            busy_q         <= 1'b1;
            if (frame_len == '0) begin
              // Empty frame goes straight to an all-zero result.
              state_q   <= ST_RESULT;
              m_valid_q <= 1'b1;
              s_ready_q <= 1'b0;
            end else begin
              state_q   <= ST_ACCUM;
              s_ready_q <= 1'b1;
              m_valid_q <= 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (beat_s) begin
            largest_q      <= largest_d;
            second_q       <= second_d;
            count_q        <= count_d;
            second_valid_q <= (count_d >= LEN_W'(2));
            if (frame_end_s) begin
              state_q   <= ST_RESULT;
              s_ready_q <= 1'b0;
              m_valid_q <= 1'b1;
            end
          end
        end
        ST_RESULT: begin
          // Start is deliberately ignored here, even in the handshake cycle.
          if (m_ready) begin
            state_q   <= ST_IDLE;
            m_valid_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          s_ready_q <= 1'b0;
          m_valid_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign s_ready        = s_ready_q;
  assign m_valid        = m_valid_q;
  assign m_largest      = largest_q;
  assign m_second       = second_q;
  assign m_count        = count_q;
  assign m_second_valid = second_valid_q;

endmodule
